// File: rtl/fpu_mul_sched_if.sv
// Handshake bundle between two requesters, the shared significand
// datapath and the result consumer of fpu_mul_sched.
interface fpu_mul_sched_if;
  logic        a_valid;
  logic        a_ready;
  logic [50:0] a_op;
  logic        b_valid;
  logic        b_ready;
  logic [50:0] b_op;
  logic [50:0] dp_op;
  logic [31:0] dp_res;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_res;

  modport master (
    output a_valid, a_op, b_valid, b_op,
    output dp_res, rsp_ready,
    input  a_ready, b_ready, dp_op,
    input  rsp_valid, rsp_id, rsp_res
  );

  modport slave (
    input  a_valid, a_op, b_valid, b_op,
    input  dp_res, rsp_ready,
    output a_ready, b_ready, dp_op,
    output rsp_valid, rsp_id, rsp_res
  );
endinterface

// File: rtl/fpu_mul_sched.sv
// Two-requester scheduler for a shared FP multiplier significand path.
// Define FPU_MUL_SCHED_RR_EN for round-robin arbitration (default: A wins).
module fpu_mul_sched #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  fpu_mul_sched_if.slave  bus,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(EXEC_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [50:0] dp_op_q;
  logic [31:0] rsp_res_q;
  logic        rsp_id_q;
  logic        rsp_valid_q;
  logic        last_grant;
  logic        gnt_a;
  logic        gnt_b;
  logic        idle;
  logic        xfer;
  logic        done;

  always_comb begin
    gnt_b = 1'b0;
`ifdef FPU_MUL_SCHED_RR_EN
    gnt_b = bus.b_valid && (!bus.a_valid || !last_grant);
`else
    gnt_b = bus.b_valid && !bus.a_valid;
`endif
    gnt_a = bus.a_valid && !gnt_b;
  end

  // Ready is gated by rst_n so nothing looks accepted during reset.
  assign idle        = (state == IDLE) && rst_n;
  assign bus.a_ready = idle && gnt_a;
  assign bus.b_ready = idle && gnt_b;
  assign xfer        = bus.a_ready || bus.b_ready;
  assign done        = (state == EXEC) && (cnt == 3'd0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (xfer) state_nxt = EXEC;
      EXEC: if (done) state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_op_q     <= '0;
      rsp_res_q   <= '0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      cnt         <= '0;
      last_grant  <= 1'b1;
    end else begin
      if (xfer) begin
        dp_op_q    <= bus.b_ready ? bus.b_op : bus.a_op;
        rsp_id_q   <= bus.b_ready;
        last_grant <= bus.b_ready;
        cnt        <= CNT_INIT;
      end else if (state == EXEC && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (done) begin
        rsp_res_q   <= bus.dp_res;
        rsp_valid_q <= 1'b1;
      end else if (state == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.dp_op     = dp_op_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign busy          = (state != IDLE);

  a_one_ready: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(bus.a_ready && bus.b_ready));

  a_op_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    busy |=> (!busy || $stable(bus.dp_op)));

  a_rsp_state: assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.rsp_valid |-> (state == RESP));

endmodule

// File: tb/tb_fpu_mul_sched.sv
// Directed bench for fpu_mul_sched: three instances with
// EXEC_CYCLES of 1, 3 and 4 sharing clock and reset.
module tb_fpu_mul_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy1, busy3, busy4;
  int   total = 0;
  int   bad = 0;

  fpu_mul_sched_if i1 ();
  fpu_mul_sched_if i3 ();
  fpu_mul_sched_if i4 ();

  fpu_mul_sched #(.EXEC_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(i1.slave), .busy(busy1));
  fpu_mul_sched #(.EXEC_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(i3.slave), .busy(busy3));
  fpu_mul_sched #(.EXEC_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(i4.slave), .busy(busy4));

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [50:0] op3;
  logic [50:0] op4;
  logic        ids [4];
  int          n;
  logic        exp_id;

  initial begin
    i1.a_valid = 0; i1.b_valid = 0; i1.a_op = '0; i1.b_op = '0;
    i1.dp_res = '0; i1.rsp_ready = 0;
    i3.a_valid = 0; i3.b_valid = 0; i3.a_op = '0; i3.b_op = '0;
    i3.dp_res = '0; i3.rsp_ready = 0;
    i4.a_valid = 0; i4.b_valid = 0; i4.a_op = '0; i4.b_op = '0;
    i4.dp_res = '0; i4.rsp_ready = 0;
    op3 = 51'h5_1234_5678_9ABC;
    op4 = 51'h3_0000_0000_00FF;

    // reset values, ready held low while in reset
    i1.a_valid = 1;
    i1.dp_res = 32'h0080_0000;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_a_ready", 64'(i1.a_ready), 64'd0);
    check("rst_rsp_valid", 64'(i1.rsp_valid), 64'd0);
    check("rst_rsp_res", 64'(i1.rsp_res), 64'd0);
    check("rst_rsp_id", 64'(i1.rsp_id), 64'd0);
    check("rst_dp_op", 64'(i1.dp_op), 64'd0);
    check("rst_last_grant", 64'(u1.last_grant), 64'd1);

    // single A op, one exec cycle
    rst_n = 1;
    #1;
    check("t1_a_ready", 64'(i1.a_ready), 64'd1);
    check("t1_b_ready", 64'(i1.b_ready), 64'd0);
    @(negedge clk);
    i1.a_valid = 0;
    check("t1_a_ready_exec", 64'(i1.a_ready), 64'd0);
    check("t1_busy", 64'(busy1), 64'd1);
    check("t1_rsp_early", 64'(i1.rsp_valid), 64'd0);
    @(negedge clk);
    check("t1_rsp_valid", 64'(i1.rsp_valid), 64'd1);
    check("t1_rsp_id", 64'(i1.rsp_id), 64'd0);
    check("t1_rsp_res", 64'(i1.rsp_res), 64'h0080_0000);
    i1.rsp_ready = 1;
    @(negedge clk);
    check("t1_rsp_done", 64'(i1.rsp_valid), 64'd0);
    check("t1_idle", 64'(busy1), 64'd0);
    i1.rsp_ready = 0;

    // B op, three exec cycles, consumer stalls five cycles
    i3.b_op = op3;
    i3.dp_res = 32'hA5A5_1234;
    i3.b_valid = 1;
    #1;
    check("t2_b_ready", 64'(i3.b_ready), 64'd1);
    check("t2_a_ready", 64'(i3.a_ready), 64'd0);
    @(negedge clk);
    i3.b_valid = 0;
    check("t2_dp_op", 64'(i3.dp_op), 64'(op3));
    check("t2_wait1", 64'(i3.rsp_valid), 64'd0);
    @(negedge clk);
    check("t2_wait2", 64'(i3.rsp_valid), 64'd0);
    @(negedge clk);
    check("t2_wait3", 64'(i3.rsp_valid), 64'd0);
    @(negedge clk);
    i3.dp_res = 32'hFFFF_FFFF;
    i3.b_op = 51'h1;
    i3.b_valid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_hold_valid", 64'(i3.rsp_valid), 64'd1);
      check("t2_hold_id", 64'(i3.rsp_id), 64'd1);
      check("t2_hold_res", 64'(i3.rsp_res), 64'hA5A5_1234);
      check("t2_hold_b_ready", 64'(i3.b_ready), 64'd0);
      check("t2_hold_dp_op", 64'(i3.dp_op), 64'(op3));
      if (i < 4) @(negedge clk);
    end
    i3.rsp_ready = 1;
    @(negedge clk);
    check("t2_rsp_done", 64'(i3.rsp_valid), 64'd0);
    check("t2_idle", 64'(busy3), 64'd0);
    check("t2_next_ready", 64'(i3.b_ready), 64'd1);
    i3.b_valid = 0;
    i3.rsp_ready = 0;

    // arbitration with both requesters valid, fresh reset
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("t3_last_grant", 64'(u1.last_grant), 64'd1);
    i1.a_op = 51'hA;
    i1.b_op = 51'hB;
    i1.dp_res = 32'h1;
    i1.a_valid = 1;
    i1.b_valid = 1;
    i1.rsp_ready = 1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (i1.rsp_valid) begin
        ids[n] = i1.rsp_id;
        n++;
      end
    end
    i1.a_valid = 0;
    i1.b_valid = 0;
    check("t3_count", 64'(n), 64'd4);
    for (int i = 0; i < n; i++) begin
`ifdef FPU_MUL_SCHED_RR_EN
      exp_id = (i % 2 == 1);
`else
      exp_id = 1'b0;
`endif
      check("t3_grant", 64'(ids[i]), 64'(exp_id));
    end
    @(negedge clk);
    i1.rsp_ready = 0;
    check("t3_idle", 64'(busy1), 64'd0);

    // reset in the middle of a four-cycle exec
    i4.a_op = op4;
    i4.dp_res = 32'h1234_5678;
    i4.a_valid = 1;
    @(negedge clk);
    i4.a_valid = 0;
    check("t4_busy", 64'(busy4), 64'd1);
    @(negedge clk);
    rst_n = 0;
    i4.a_valid = 1;
    #1;
    check("t4_abort_busy", 64'(busy4), 64'd0);
    check("t4_abort_valid", 64'(i4.rsp_valid), 64'd0);
    check("t4_abort_dp_op", 64'(i4.dp_op), 64'd0);
    check("t4_abort_ready", 64'(i4.a_ready), 64'd0);
    @(negedge clk);
    rst_n = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) i4.a_valid = 0;
      check("t4_latency", 64'(i4.rsp_valid), 64'(c == 5));
    end
    check("t4_rsp_id", 64'(i4.rsp_id), 64'd0);
    check("t4_rsp_res", 64'(i4.rsp_res), 64'h1234_5678);
    i4.rsp_ready = 1;
    @(negedge clk);
    check("t4_rsp_done", 64'(i4.rsp_valid), 64'd0);
    check("t4_idle", 64'(busy4), 64'd0);
    i4.rsp_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_mul_sched.md
FPU_MUL_SCHED -- requirements
Module: fpu_mul_sched

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, meaning: cycles the shared significand datapath is given to settle, legal range 1..8.
REQ-002 CLK  input  1  single clock, all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 a_valid  input  1  requester A has an operation.
REQ-005 a_ready  output  1  requester A operation accepted this cycle.
REQ-006 a_op  input  51  requester A operand bundle {Sz, R_mode[1:0], zero_Ey, zero_Ex, My[22:0], Mx[22:0]}.
REQ-007 b_valid, b_ready, b_op  same as REQ-004..006, requester B.
REQ-008 dp_op  output  51  registered operand bundle to the shared significand datapath, same packing as a_op.
REQ-009 dp_res  input  32  datapath result {inexact_flag, Overflow_after_round, SHL[4:0], ovf, Mz[23:0]}.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer takes result.
REQ-012 rsp_id  output  1  owner of result, 0=A, 1=B.
REQ-013 rsp_res  output  32  captured dp_res.
REQ-014 busy  output  1  high when state is not IDLE.

Function
REQ-015 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-016 IDLE: grant computed combinationally from a_valid/b_valid; granted requester's ready = 1, other ready = 0; no valid -> both ready 0.
REQ-017 Transfer on valid && ready: dp_op <= granted op, id <= granted requester, counter <= EXEC_CYCLES-1, state -> EXEC.
REQ-018 a_ready and b_ready SHALL be 0 in EXEC and RESP; never both 1.
REQ-019 EXEC: counter decrements each cycle; in the cycle counter == 0, rsp_res <= dp_res, rsp_valid <= 1, state -> RESP.
REQ-020 Latency: transfer at edge k -> rsp_valid high after edge k+EXEC_CYCLES.
REQ-021 dp_op SHALL remain stable from transfer until the return to IDLE.
REQ-022 RESP: rsp_valid, rsp_id, rsp_res held stable until rsp_ready; on rsp_valid && rsp_ready -> IDLE, rsp_valid <= 0.
REQ-023 No acceptance in the same cycle as the response handshake; the next acceptance is possible at the earliest one cycle after the return to IDLE (max throughput one op per EXEC_CYCLES+2 cycles).
REQ-024 last_grant register updated on every transfer to the granted requester id.
REQ-025 Requesters SHALL keep op stable while valid && !ready; the block does not buffer unaccepted ops.

Reset
REQ-026 RST low: state = IDLE, dp_op = 0, rsp_res = 0, rsp_id = 0, rsp_valid = 0, counter = 0, last_grant = 1 (B), busy = 0, immediately and asynchronously.
REQ-027 a_ready and b_ready forced 0 while RST low.
REQ-028 Reset mid-EXEC or mid-RESP aborts the operation; no response is produced for it.

Configuration
REQ-029 Macro FPU_MUL_SCHED_RR_EN defined: both valid in IDLE -> grant the requester not equal to last_grant (round-robin).
REQ-030 Macro undefined: both valid -> A always granted (fixed priority); last_grant is still maintained but does not affect grant.

Verification
REQ-031 EXEC_CYCLES=1, a_valid only, a_op=51'h0, model dp_res=32'h0080_0000 -> a_ready 1 for one cycle, rsp_valid after 1 edge, rsp_id=0, rsp_res=32'h0080_0000.
REQ-032 EXEC_CYCLES=3, b_valid only, rsp_ready held 0 for 5 cycles -> rsp_valid after 3 edges, rsp_res/rsp_id=1 stable for all 5 cycles, b_ready 0 throughout.
REQ-033 RR_EN defined, a_valid=b_valid=1 continuously for 4 ops, rsp_ready=1 -> grant order A,B,A,B; undefined -> A,A,A,A.
REQ-034 dp_res changes during RESP (model drives 32'hFFFF_FFFF) -> rsp_res keeps value captured at end of EXEC.
REQ-035 RST asserted during EXEC (EXEC_CYCLES=4, cycle 2) -> rsp_valid 0, busy 0, state IDLE; after release with a_valid=1 -> next result returned normally with rsp_id=0.
REQ-036 Assertions: never a_ready && b_ready; dp_op stable while busy; rsp_valid implies state RESP.
